iter_alu: RTL and testbench

//  Parametrised multi-cycle ALU: the successor of the combinational integer ALU.
//  It executes the RV32I ALU ops plus RV32M multiply/divide/remainder behind

---
 rtl/iter_alu.sv | 214 +++++++++++++++++++++
 tb/tb_iter_alu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Multi-cycle integer ALU: RV32I ALU ops in one cycle, RV32M mul/div/rem by
// radix-2 iteration, all behind valid/ready handshakes on both sides.
module iter_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             busy
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_MUL   = 5'd10;
    localparam logic [4:0] OP_MULH  = 5'd11;
    localparam logic [4:0] OP_MULHU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_REM   = 5'd15;
    localparam logic [4:0] OP_REMU  = 5'd16;

    localparam logic [WIDTH-1:0]   MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   hi, hi_d, lo, lo_d, md, md_d;
    logic [WIDTH-1:0]   result_d;
    logic [4:0]         op_q, op_q_d;
    logic               neg, neg_d, error_d;
    logic [SHAMT_W-1:0] cnt, cnt_d;

    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic               is_mop, is_div, is_signed, invalid;
    logic               b_zero, div_ovf, special;
    logic [WIDTH-1:0]   fast_res, op_a, op_b;
    logic               load_neg;

    logic               q_div;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo, final_res;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Decode of the operation presented at the input
    assign shamt     = b[SHAMT_W-1:0];
    assign is_mop    = (op >= OP_MUL) && (op <= OP_REMU);
    assign is_div    = (op >= OP_DIV) && (op <= OP_REMU);
    assign is_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign invalid   = (op > OP_REMU);
    assign b_zero    = (b == '0);
    assign div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == '1);
    assign special   = is_div && (b_zero || div_ovf);

    assign op_a     = (is_signed && a[WIDTH-1]) ? negate(a) : a;
    assign op_b     = (is_signed && b[WIDTH-1]) ? negate(b) : b;
    assign load_neg = (op == OP_REM) ? a[WIDTH-1]
                    : (is_signed && (a[WIDTH-1] ^ b[WIDTH-1]));

    // Single-cycle results, including the divide special cases
    always_comb begin
        fast_res = '0;
        case (op)
            OP_ADD:           fast_res = a + b;
            OP_SUB:           fast_res = a - b;
            OP_SLL:           fast_res = a << shamt;
            OP_SLT:           fast_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU:          fast_res = WIDTH'(a < b);
            OP_XOR:           fast_res = a ^ b;
            OP_SRL:           fast_res = a >> shamt;
            OP_SRA:           fast_res = WIDTH'($signed(a) >>> shamt);
            OP_OR:            fast_res = a | b;
            OP_AND:           fast_res = a & b;
            OP_DIV, OP_DIVU:  fast_res = b_zero ? '1 : a;
            OP_REM, OP_REMU:  fast_res = b_zero ? a : '0;
            default:          fast_res = '0;
        endcase
    end

    // One radix-2 step: shift-add multiply in {hi,lo}, restoring divide with rem in hi
    assign q_div     = (op_q >= OP_DIV);
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, md};

    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        if (q_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up applied on the last iteration
    always_comb begin
        final_res = '0;
        case (op_q)
            OP_MUL:          final_res = step_lo;
            OP_MULH:         final_res = neg ? (~step_hi + WIDTH'(step_lo == '0)) : step_hi;
            OP_MULHU:        final_res = step_hi;
            OP_DIV, OP_DIVU: final_res = neg ? negate(step_lo) : step_lo;
            OP_REM, OP_REMU: final_res = neg ? negate(step_hi) : step_hi;
            default:         final_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state;
        hi_d     = hi;
        lo_d     = lo;
        md_d     = md;
        op_q_d   = op_q;
        neg_d    = neg;
        cnt_d    = cnt;
        result_d = result;
        error_d  = error;
        case (state)
            S_IDLE, S_DONE: begin
                if ((state == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    op_q_d = op;
                    if (is_mop && !special) begin
                        state_d = S_ITER;
                        hi_d    = '0;
                        lo_d    = is_div ? op_a : op_b;
                        md_d    = is_div ? op_b : op_a;
                        neg_d   = load_neg;
                        cnt_d   = '0;
                    end else begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                        error_d  = invalid;
                    end
                end
            end
            S_ITER: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt + SHAMT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                    error_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hi        <= '0;
            lo        <= '0;
            md        <= '0;
            op_q      <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            error     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            hi        <= hi_d;
            lo        <= lo_d;
            md        <= md_d;
            op_q      <= op_q_d;
            neg       <= neg_d;
            cnt       <= cnt_d;
            out_valid <= (state_d == S_DONE);
            result    <= result_d;
            error     <= error_d;
            busy      <= (state_d == S_ITER);
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: a WIDTH=32 instance with hand-computed vectors
// and a WIDTH=8 instance checked against a behavioural reference function.
module tb_iter_alu;
    localparam logic [4:0] OP_ADD = 5'd0, OP_SRA = 5'd7, OP_AND = 5'd9, OP_MUL = 5'd10,
                           OP_MULH = 5'd11, OP_MULHU = 5'd12, OP_DIV = 5'd13,
                           OP_DIVU = 5'd14, OP_REM = 5'd15, OP_REMU = 5'd16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv32 = 1'b0, or32 = 1'b0, ir32, ov32, err32, busy32;
    logic [4:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0, res32;

    logic        iv8 = 1'b0, or8 = 1'b0, ir8, ov8, err8, busy8;
    logic [4:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, res8;

    int errors = 0;
    int checks = 0;

    iter_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .result(res32),
        .error(err32), .busy(busy32)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .result(res8),
        .error(err8), .busy(busy8)
    );

    // Issue one op on the 32-bit instance, wait (bounded) for its result, then take it
    task automatic run32(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic e, output int lat, output int bcnt);
        @(negedge clk);
        op32 = o; a32 = x; b32 = y; iv32 = 1'b1; or32 = 1'b0;
        @(posedge clk);
        #1;
        iv32 = 1'b0; a32 = ~x; b32 = ~y;
        lat = 0; bcnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy32) bcnt++;
            if (ov32) break;
        end
        r = res32; e = err32;
        or32 = 1'b1;
        @(posedge clk);
        #1 or32 = 1'b0;
    endtask

    task automatic run8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] r, output logic e, output int lat);
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk);
        #1;
        iv8 = 1'b0; a8 = ~x; b8 = ~y;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (ov8) break;
        end
        r = res8; e = err8;
        or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
    endtask

    function automatic logic [7:0] ref8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] ps, pu;
        logic        ovf;
        ps  = {{8{x[7]}}, x} * {{8{y[7]}}, y};
        pu  = {8'h00, x} * {8'h00, y};
        ovf = (x == 8'h80) && (y == 8'hFF);
        case (o)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return x << y[2:0];
            5'd3:  return {7'b0, $signed(x) < $signed(y)};
            5'd4:  return {7'b0, x < y};
            5'd5:  return x ^ y;
            5'd6:  return x >> y[2:0];
            5'd7:  return 8'($signed(x) >>> y[2:0]);
            5'd8:  return x | y;
            5'd9:  return x & y;
            5'd10: return pu[7:0];
            5'd11: return ps[15:8];
            5'd12: return pu[15:8];
            5'd13: return (y == 0) ? 8'hFF : ovf ? x : 8'($signed(x) / $signed(y));
            5'd14: return (y == 0) ? 8'hFF : x / y;
            5'd15: return (y == 0) ? x : ovf ? 8'h00 : 8'($signed(x) % $signed(y));
            5'd16: return (y == 0) ? x : x % y;
            default: return 8'h00;
        endcase
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (ov32 !== 1'b0 || res32 !== 32'h0 || err32 !== 1'b0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL reset32: ov=%b res=%h err=%b busy=%b, want all zero", ov32, res32, err32, busy32);
        end
        checks++;
        if (ir32 !== 1'b1 || ov8 !== 1'b0 || res8 !== 8'h0) begin
            errors++;
            $display("FAIL reset_ready: ir32=%b ov8=%b res8=%h, want 1 0 00", ir32, ov8, res8);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] r; logic e; int lat, bc;
        run32(OP_ADD, 32'd20, 32'd3, r, e, lat, bc);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
        checks++;
        if (r !== 32'd23 || e !== 1'b0) begin errors++; $display("FAIL add: got %h err=%b want 00000017 err=0", r, e); end
        run32(OP_SRA, 32'hFFFF_FFFE, 32'd33, r, e, lat, bc);
        checks++;
        if (r !== 32'hFFFF_FFFF || lat !== 1) begin errors++; $display("FAIL sra: got %h lat %0d want ffffffff lat 1", r, lat); end
    endtask

    task automatic test_mul();
        logic [31:0] r; logic e; int lat, bc;
        run32(OP_MULH, 32'h8000_0000, 32'd2, r, e, lat, bc);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL mulh_latency: got %0d want 33", lat); end
        checks++;
        if (bc !== 32) begin errors++; $display("FAIL mulh_busy: got %0d cycles want 32", bc); end
        checks++;
        if (r !== 32'hFFFF_FFFF || e !== 1'b0) begin errors++; $display("FAIL mulh: got %h want ffffffff", r); end
        run32(OP_MULHU, 32'h8000_0000, 32'd2, r, e, lat, bc);
        checks++;
        if (r !== 32'd1) begin errors++; $display("FAIL mulhu: got %h want 00000001", r); end
        run32(OP_MUL, 32'hFFFF_FFF9, 32'd6, r, e, lat, bc);
        checks++;
        if (r !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul: got %h want ffffffd6", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; logic e; int lat, bc;
        run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, e, lat, bc);
        checks++;
        if (r !== 32'hFFFF_FFFD || lat !== 33) begin errors++; $display("FAIL div: got %h lat %0d want fffffffd lat 33", r, lat); end
        run32(OP_REM, 32'hFFFF_FFF9, 32'd2, r, e, lat, bc);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem: got %h want ffffffff", r); end
        run32(OP_DIVU, 32'd7, 32'd0, r, e, lat, bc);
        checks++;
        if (r !== 32'hFFFF_FFFF || lat !== 1 || e !== 1'b0) begin errors++; $display("FAIL divu_by0: got %h lat %0d err %b want ffffffff lat 1 err 0", r, lat, e); end
        run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, e, lat, bc);
        checks++;
        if (r !== 32'h8000_0000 || lat !== 1) begin errors++; $display("FAIL div_ovf: got %h lat %0d want 80000000 lat 1", r, lat); end
        run32(OP_REMU, 32'd100, 32'd7, r, e, lat, bc);
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL remu: got %h want 00000002", r); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op32 = OP_ADD; a32 = 32'd5; b32 = 32'd6; iv32 = 1'b1; or32 = 1'b0;
        @(posedge clk);
        #1 iv32 = 1'b0;
        @(negedge clk);
        checks++;
        if (ov32 !== 1'b1 || res32 !== 32'd11) begin errors++; $display("FAIL hold_first: ov=%b res=%h want 1 0000000b", ov32, res32); end
        for (int i = 0; i < 5; i++) begin
            a32 = 32'(i); b32 = 32'(i * 3);
            @(negedge clk);
            checks++;
            if (ov32 !== 1'b1 || res32 !== 32'd11 || ir32 !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: ov=%b res=%h ir=%b want 1 0000000b 0", ov32, res32, ir32);
            end
        end
        or32 = 1'b1; iv32 = 1'b1; op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1;
        #1;
        checks++;
        if (ir32 !== 1'b1) begin errors++; $display("FAIL ready_on_take: ir=%b want 1", ir32); end
        @(posedge clk);
        #1 iv32 = 1'b0; or32 = 1'b0;
        @(negedge clk);
        checks++;
        if (ov32 !== 1'b1 || res32 !== 32'd2) begin errors++; $display("FAIL no_bubble: ov=%b res=%h want 1 00000002", ov32, res32); end
        or32 = 1'b1;
        @(posedge clk);
        #1 or32 = 1'b0;
    endtask

    task automatic test_invalid();
        logic [31:0] r; logic e; int lat, bc;
        run32(5'd20, 32'h1234_5678, 32'h9, r, e, lat, bc);
        checks++;
        if (e !== 1'b1 || r !== 32'h0 || lat !== 1) begin errors++; $display("FAIL invalid_op: err %b res %h lat %0d want 1 00000000 1", e, r, lat); end
        run32(OP_AND, 32'hF0, 32'h3C, r, e, lat, bc);
        checks++;
        if (e !== 1'b0 || r !== 32'h30) begin errors++; $display("FAIL and_after_invalid: err %b res %h want 0 00000030", e, r); end
    endtask

    task automatic test_reset_mid_iter();
        logic [31:0] r; logic e; int lat, bc; bit seen;
        @(negedge clk);
        op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7; iv32 = 1'b1;
        @(posedge clk);
        #1 iv32 = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy32 !== 1'b1) begin errors++; $display("FAIL busy_mid_iter: got %b want 1", busy32); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov32 !== 1'b0 || res32 !== 32'h0 || err32 !== 1'b0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ov=%b res=%h err=%b busy=%b want all zero", ov32, res32, err32, busy32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ov32 || busy32) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL stale_output: saw out_valid/busy after reset"); end
        run32(OP_ADD, 32'd20, 32'd3, r, e, lat, bc);
        checks++;
        if (r !== 32'd23 || lat !== 1) begin errors++; $display("FAIL add_after_reset: got %h lat %0d want 00000017 lat 1", r, lat); end
    endtask

    task automatic test_width8();
        logic [4:0] ops [12];
        logic [7:0] as  [12];
        logic [7:0] bs  [12];
        int         lats[12];
        logic [7:0] r; logic e; int lat;
        ops = '{OP_ADD, OP_SRA, OP_DIV, OP_REM, OP_DIVU, OP_DIV, OP_REM, OP_MULH, OP_MULHU, OP_MUL, OP_REMU, OP_DIVU};
        as  = '{8'd20, 8'hFE, 8'hF9, 8'hF9, 8'd7, 8'h80, 8'h80, 8'h80, 8'h80, 8'hF9, 8'd100, 8'hC8};
        bs  = '{8'd3, 8'd33, 8'd2, 8'd2, 8'd0, 8'hFF, 8'hFF, 8'd2, 8'd2, 8'hF9, 8'd7, 8'd9};
        lats = '{1, 1, 9, 9, 1, 1, 1, 9, 9, 9, 9, 9};
        for (int i = 0; i < 12; i++) begin
            run8(ops[i], as[i], bs[i], r, e, lat);
            checks++;
            if (r !== ref8(ops[i], as[i], bs[i]) || e !== 1'b0) begin
                errors++;
                $display("FAIL w8_result[%0d] op %0d: got %h err %b want %h err 0", i, ops[i], r, e, ref8(ops[i], as[i], bs[i]));
            end
            checks++;
            if (lat !== lats[i]) begin
                errors++;
                $display("FAIL w8_latency[%0d] op %0d: got %0d want %0d", i, ops[i], lat, lats[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mul();
        test_div();
        test_back_to_back();
        test_invalid();
        test_reset_mid_iter();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
